// File: rtl/fetch_pkg.sv
// Shared fetch-stage types, defaults and width helpers.
// BTB layout helpers are used by fetch_btb (FETCH_PC_BTB_EN builds).
package fetch_pkg;

  localparam int          XLEN_D         = 32;
  localparam int          INSTR_BYTES_D  = 4;
  localparam int          BTB_ENTRIES_D  = 16;
  localparam logic [31:0] RESET_VECTOR_D = 32'h0000_0000;

  function automatic int off_w(input int bytes);
    return $clog2(bytes);
  endfunction

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int tag_w(
    input int xlen,
    input int bytes,
    input int entries
  );
    return xlen - $clog2(bytes) - $clog2(entries);
  endfunction

  localparam int TAG_W_D = XLEN_D - 2 - 4;

  typedef struct packed {
    logic               valid;
    logic [TAG_W_D-1:0] tag;
    logic [XLEN_D-1:0]  target;
  } btb_entry_t;

endpackage

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer: combinational lookup,
// clocked update, valid bits cleared by reset.
module fetch_btb
  import fetch_pkg::*;
#(
  parameter int XLEN        = XLEN_D,
  parameter int INSTR_BYTES = INSTR_BYTES_D,
  parameter int BTB_ENTRIES = BTB_ENTRIES_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] lookup_pc,
  output logic            hit,
  output logic [XLEN-1:0] target,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic [XLEN-1:0] upd_target,
  input  logic            upd_taken
);

  localparam int OFF = off_w(INSTR_BYTES);
  localparam int IDX = idx_w(BTB_ENTRIES);
  localparam int TW  = tag_w(XLEN, INSTR_BYTES, BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] vld;
  logic [TW-1:0]          tags [BTB_ENTRIES];
  logic [XLEN-1:0]        tgts [BTB_ENTRIES];

  logic [IDX-1:0] l_idx;
  logic [IDX-1:0] u_idx;
  logic [TW-1:0]  l_tag;
  logic [TW-1:0]  u_tag;
  logic           unused_lo;

  assign l_idx = lookup_pc[OFF+IDX-1:OFF];
  assign l_tag = lookup_pc[XLEN-1:OFF+IDX];
  assign u_idx = upd_pc[OFF+IDX-1:OFF];
  assign u_tag = upd_pc[XLEN-1:OFF+IDX];

  assign unused_lo = ^{lookup_pc[OFF-1:0], upd_pc[OFF-1:0]};

  assign hit    = vld[l_idx] && (tags[l_idx] == l_tag);
  assign target = tgts[l_idx];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld <= '0;
    end else if (upd_valid) begin
      if (upd_taken) begin
        vld[u_idx] <= 1'b1;
      end else if (tags[u_idx] == u_tag) begin
        vld[u_idx] <= 1'b0;
      end
    end
  end

  // Payload needs no reset; it is qualified by vld.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tags[u_idx] <= u_tag;
      tgts[u_idx] <= upd_target;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC register and next-PC select (trap > redirect > stall > BTB > seq).
// Optional BTB enabled by defining FETCH_PC_BTB_EN.
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN         = XLEN_D,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(RESET_VECTOR_D),
  parameter int              INSTR_BYTES  = INSTR_BYTES_D,
  parameter int              BTB_ENTRIES  = BTB_ENTRIES_D
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            pc_valid_o,
  output logic            pred_taken_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(INSTR_BYTES - 1);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] tgt_raw;
  logic [XLEN-1:0] pred_target;
  logic            valid_q;
  logic            mis_q;
  logic            mis_d;
  logic            pred_hit;

  assign pc_plus_o = pc_q + XLEN'(INSTR_BYTES);
  assign tgt_raw   = trap_i ? trap_pc_i : redirect_pc_i;

`ifdef FETCH_PC_BTB_EN
  fetch_btb #(
    .XLEN        (XLEN),
    .INSTR_BYTES (INSTR_BYTES),
    .BTB_ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk        (clk),
    .rst        (rst),
    .lookup_pc  (pc_q),
    .hit        (pred_hit),
    .target     (pred_target),
    .upd_valid  (upd_valid_i),
    .upd_pc     (upd_pc_i),
    .upd_target (upd_target_i),
    .upd_taken  (upd_taken_i)
  );
`else
  logic unused_btb;

  assign pred_hit    = 1'b0;
  assign pred_target = '0;
  assign unused_btb  = ^{upd_valid_i, upd_pc_i,
                         upd_target_i, upd_taken_i,
                         32'(BTB_ENTRIES)};
`endif

  // The first edge after reset only raises valid (one bubble).
  always_comb begin
    pc_d  = pc_q;
    mis_d = 1'b0;
    if (!valid_q) begin
      pc_d = pc_q;
    end else if (trap_i || redirect_i) begin
      pc_d  = tgt_raw & ~LOW_MASK;
      mis_d = |(tgt_raw & LOW_MASK);
    end else if (stall_i) begin
      mis_d = mis_q;
    end else if (pred_hit) begin
      pc_d = pred_target;
    end else begin
      pc_d = pc_plus_o;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      mis_q   <= mis_d;
    end
  end

  assign pc_o         = pc_q;
  assign pc_valid_o   = valid_q;
  assign misalign_o   = mis_q;
  assign pred_taken_o = pred_hit;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit against a behavioural model.
// Follows FETCH_PC_BTB_EN to decide whether BTB predictions are expected.
module tb_fetch_pc_unit;

`ifdef FETCH_PC_BTB_EN
  localparam bit BTB = 1'b1;
`else
  localparam bit BTB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        trap_i;
  logic [31:0] trap_pc_i;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic [31:0] upd_target_i;
  logic        upd_taken_i;
  logic [31:0] pc_o;
  logic [31:0] pc_plus_o;
  logic        pc_valid_o;
  logic        pred_taken_o;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] m_pc;
  bit          m_valid;
  bit          m_mis;
  bit          m_v   [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];

  fetch_pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .trap_i        (trap_i),
    .trap_pc_i     (trap_pc_i),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_target_i  (upd_target_i),
    .upd_taken_i   (upd_taken_i),
    .pc_o          (pc_o),
    .pc_plus_o     (pc_plus_o),
    .pc_valid_o    (pc_valid_o),
    .pred_taken_o  (pred_taken_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'((pc / 4) % 16);
    return BTB && m_v[i] && (m_tag[i] == pc / 64);
  endfunction

  function automatic logic [31:0] m_target(input logic [31:0] pc);
    return m_tgt[int'((pc / 4) % 16)];
  endfunction

  task automatic m_reset();
    m_pc    = 32'h0;
    m_valid = 1'b0;
    m_mis   = 1'b0;
    for (int i = 0; i < 16; i++) m_v[i] = 1'b0;
  endtask

  task automatic clear_in();
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    trap_i        = 1'b0;
    trap_pc_i     = 32'h0;
    upd_valid_i   = 1'b0;
    upd_pc_i      = 32'h0;
    upd_target_i  = 32'h0;
    upd_taken_i   = 1'b0;
  endtask

  // One clock edge: evaluate the model from the held inputs, then sample.
  task automatic step();
    logic [31:0] n_pc;
    logic [31:0] t;
    bit          n_mis;
    int          ui;
    n_pc  = m_pc;
    n_mis = 1'b0;
    if (!m_valid) begin
      n_pc = m_pc;
    end else if (trap_i || redirect_i) begin
      t     = trap_i ? trap_pc_i : redirect_pc_i;
      n_pc  = t - (t % 4);
      n_mis = (t % 4) != 0;
    end else if (stall_i) begin
      n_mis = m_mis;
    end else if (m_hit(m_pc)) begin
      n_pc = m_target(m_pc);
    end else begin
      n_pc = m_pc + 32'd4;
    end
    if (upd_valid_i) begin
      ui = int'((upd_pc_i / 4) % 16);
      if (upd_taken_i) begin
        m_v[ui]   = 1'b1;
        m_tag[ui] = upd_pc_i / 64;
        m_tgt[ui] = upd_target_i;
      end else if (m_tag[ui] == upd_pc_i / 64) begin
        m_v[ui] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_pc    = n_pc;
    m_mis   = n_mis;
    m_valid = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] seq [4];
    seq = '{32'h0, 32'h4, 32'h8, 32'hC};
    clear_in();
    rst = 1'b0;
    m_reset();
    #12;
    total++;
    if ({pc_valid_o, misalign_o, pred_taken_o, pc_o} !== 35'h0) begin
      bad++;
      $display("FAIL reset_state got v=%b m=%b p=%b pc=%h want 0,0,0,0",
               pc_valid_o, misalign_o, pred_taken_o, pc_o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      total++;
      if (pc_o !== seq[k] || pc_valid_o !== 1'b1) begin
        bad++;
        $display("FAIL reset_seq[%0d] got pc=%h v=%b want pc=%h v=1",
                 k, pc_o, pc_valid_o, seq[k]);
      end
    end
  endtask

  task automatic test_stall();
    step();
    for (int k = 0; k < 3; k++) begin
      stall_i = 1'b1;
      step();
      total++;
      if (pc_o !== 32'h10) begin
        bad++;
        $display("FAIL stall_hold[%0d] got %h want 00000010", k, pc_o);
      end
    end
    stall_i = 1'b0;
    step();
    total++;
    if (pc_o !== 32'h14) begin
      bad++;
      $display("FAIL stall_release got %h want 00000014", pc_o);
    end
  endtask

  task automatic test_stall_redirect();
    stall_i       = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    clear_in();
    total++;
    if (pc_o !== 32'h200 || misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL stall_redirect got pc=%h m=%b want 00000200,0",
               pc_o, misalign_o);
    end
  endtask

  task automatic test_trap_redirect();
    trap_i        = 1'b1;
    trap_pc_i     = 32'h80;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    total++;
    if (pc_o !== 32'h80) begin
      bad++;
      $display("FAIL trap_wins got %h want 00000080", pc_o);
    end
    trap_i        = 1'b0;
    redirect_pc_i = 32'h102;
    step();
    clear_in();
    total++;
    if (pc_o !== 32'h100 || misalign_o !== 1'b1) begin
      bad++;
      $display("FAIL misalign_set got pc=%h m=%b want 00000100,1",
               pc_o, misalign_o);
    end
    step();
    total++;
    if (pc_o !== 32'h104 || misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL misalign_clear got pc=%h m=%b want 00000104,0",
               pc_o, misalign_o);
    end
  endtask

  task automatic test_misalign_stall();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h303;
    step();
    redirect_i = 1'b0;
    stall_i    = 1'b1;
    step();
    total++;
    if (pc_o !== 32'h300 || misalign_o !== 1'b1) begin
      bad++;
      $display("FAIL misalign_hold got pc=%h m=%b want 00000300,1",
               pc_o, misalign_o);
    end
    clear_in();
    step();
    total++;
    if (pc_o !== 32'h304 || misalign_o !== 1'b0) begin
      bad++;
      $display("FAIL misalign_drop got pc=%h m=%b want 00000304,0",
               pc_o, misalign_o);
    end
  endtask

  task automatic test_wrap();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    clear_in();
    total++;
    if (pc_o !== 32'hFFFF_FFFC || pc_plus_o !== 32'h0) begin
      bad++;
      $display("FAIL wrap_plus got pc=%h plus=%h want fffffffc,00000000",
               pc_o, pc_plus_o);
    end
    step();
    total++;
    if (pc_o !== 32'h0) begin
      bad++;
      $display("FAIL wrap_pc got %h want 00000000", pc_o);
    end
  endtask

  task automatic test_btb();
    upd_valid_i  = 1'b1;
    upd_pc_i     = 32'h40;
    upd_target_i = 32'h100;
    upd_taken_i  = 1'b1;
    step();
    clear_in();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    redirect_i = 1'b0;
    stall_i    = 1'b1;
    step();
    total++;
    if (pc_o !== 32'h40 || pred_taken_o !== BTB) begin
      bad++;
      $display("FAIL btb_hit_stall got pc=%h p=%b want 00000040,%b",
               pc_o, pred_taken_o, BTB);
    end
    stall_i = 1'b0;
    step();
    total++;
    if (pc_o !== (BTB ? 32'h100 : 32'h44)) begin
      bad++;
      $display("FAIL btb_follow got %h want %h",
               pc_o, BTB ? 32'h100 : 32'h44);
    end
    upd_valid_i   = 1'b1;
    upd_pc_i      = 32'h40;
    upd_taken_i   = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h40;
    step();
    clear_in();
    total++;
    if (pc_o !== 32'h40 || pred_taken_o !== 1'b0) begin
      bad++;
      $display("FAIL btb_clear got pc=%h p=%b want 00000040,0",
               pc_o, pred_taken_o);
    end
    step();
    total++;
    if (pc_o !== 32'h44) begin
      bad++;
      $display("FAIL btb_cleared_seq got %h want 00000044", pc_o);
    end
  endtask

  task automatic test_reset_mid();
    trap_i        = 1'b1;
    trap_pc_i     = 32'h80;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    @(posedge clk);
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    total++;
    if ({pc_valid_o, misalign_o, pred_taken_o, pc_o} !== 35'h0) begin
      bad++;
      $display("FAIL reset_mid got v=%b m=%b p=%b pc=%h want 0,0,0,0",
               pc_valid_o, misalign_o, pred_taken_o, pc_o);
    end
    clear_in();
    @(negedge clk);
    rst = 1'b1;
    step();
    total++;
    if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_bubble got pc=%h v=%b want 00000000,1",
               pc_o, pc_valid_o);
    end
  endtask

  task automatic test_random();
    logic [66:0] got;
    logic [66:0] exp;
    for (int n = 0; n < 400; n++) begin
      trap_i        = ($urandom_range(0, 15) == 0);
      trap_pc_i     = 32'($urandom_range(0, 255));
      redirect_i    = ($urandom_range(0, 7) == 0);
      redirect_pc_i = 32'($urandom_range(0, 255));
      stall_i       = ($urandom_range(0, 4) == 0);
      upd_valid_i   = ($urandom_range(0, 2) == 0);
      upd_pc_i      = 32'($urandom_range(0, 63)) * 4;
      upd_target_i  = 32'($urandom_range(0, 63)) * 4;
      upd_taken_i   = ($urandom_range(0, 2) != 0);
      step();
      got = {pc_valid_o, misalign_o, pred_taken_o, pc_o, pc_plus_o};
      exp = {m_valid, m_mis, m_hit(m_pc), m_pc, m_pc + 32'd4};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL random[%0d] got v,m,p,pc,plus=%h want %h",
                 n, got, exp);
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_stall();
    test_stall_redirect();
    test_trap_redirect();
    test_misalign_stall();
    test_wrap();
    test_btb();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
